vga_sync_decoder: RTL and testbench
===================================

// Module: vga_sync_decoder
// PURPOSE
//  Receive-side counterpart of the VGA timing generator. Samples a hsync/vsync/valid
//  raster stream, measures line and frame periods, and runs a lock FSM against the
//  expected totals. Once locked, recovers pixel coordinates x/y.
//  Sits on video loopback and capture paths, and is the checker for the display chain.
// PARAMETERS
//  H_TOTAL          800  expected pix_en ticks per line (hsync edge to hsync edge)
//  V_TOTAL          525  expected lines per frame (hsync edges per vsync period)
//  LOCK_FRAMES      2    consecutive fault-free frames required in TRACK before LOCKED
//  SYNC_ACTIVE_LOW  1    1: sync asserted = 0 (640x480 style); 0: asserted = 1
// PORTS
//  clk      in   1   system clock; the only clock
//  reset    in   1   asynchronous, active-low reset
//  pix_en   in   1   pixel strobe; inputs are sampled only on clk edges where pix_en=1
//  hsync    in   1   horizontal sync, polarity per SYNC_ACTIVE_LOW
//  vsync    in   1   vertical sync, polarity per SYNC_ACTIVE_LOW
//  valid    in   1   active-video (data enable) from the source
//  x        out  10  recovered column of the last active pixel
//  y        out  9   recovered row of the last active pixel
//  rx_valid out  1   1-clk strobe: x/y describe a pixel sampled while LOCKED
//  locked   out  1   1 while FSM is in LOCKED
//  err      out  1   1-clk pulse on a timing fault in TRACK or LOCKED
//  h_total  out  11  last measured line period (pix_en ticks)
//  v_total  out  10  last measured frame period (lines)
// BEHAVIOUR
//  - Reset (reset=0, async): all outputs 0; FSM=SEARCH; all counters/flags/history 0.
//  - All state advances only on pix_en=1 cycles, except one-clk pulses (rx_valid, err),
//    which self-clear on the following clk.
//  - Previous samples hs_q/vs_q/de_q update each pix_en tick.
//    hs_edge/vs_edge = transition into the asserted level vs the previous sample.
//  - h_cnt (11b): at hs_edge h_cnt<=1, else h_cnt+1, saturating at 2047.
//    Line period P_h = h_cnt value held on the hs_edge tick. Latched into h_total.
//    h_seen<=1 on any hs_edge; h_seen is cleared on entry to SEARCH.
//  - v_cnt (10b, saturating): +1 per hs_edge; on vs_edge v_cnt<=0.
//    Frame period P_v = v_cnt + (hs_edge?1:0) on the vs_edge tick (a coincident hs
//    edge counts toward the ending frame). Latched into v_total.
//  - Fault (evaluated only in TRACK/LOCKED), any of:
//    hs_edge with h_seen=1 and P_h!=H_TOTAL; vs_edge with P_v!=V_TOTAL; h_cnt==2047.
//  - FSM:
//    SEARCH -> TRACK on vs_edge, good<=0; this vs_edge is not checked.
//    TRACK  -> SEARCH on fault, err=1.
//    TRACK: fault-free vs_edge does good+1; on reaching LOCK_FRAMES -> LOCKED.
//    LOCKED -> SEARCH on fault, err=1.
//    locked is registered: it rises/falls 1 clk after the deciding tick.
//  - Fault and fault-free frame completion on the same tick: fault wins.
//  - Coordinates, per pix_en tick:
//    valid=1: x <= de_q ? x+1 : 0; x saturates at 1023.
//    valid falling edge: y+1, saturating at 511. vs_edge: y<=0 (wins over the increment).
//    x/y hold when valid=0.
//  - rx_valid = 1 on the clk after a pix_en tick with valid=1 and FSM==LOCKED
//    (state before that tick's update). Latency 1 clk, aligned with updated x/y.
//  - pix_en gaps of any length are transparent: no counting, no edges.
//  - Async reset mid-frame: immediate return to reset values; relock from SEARCH.
// TESTING
//  - Nominal 640x480 (800x525, pix_en every 4th clk), 4 frames -> locked rises 1 clk
//    after 3rd vs_edge; h_total=800, v_total=525; err never.
//  - While locked, 1 frame -> x runs 0..639, y 0..479; exactly 307200 rx_valid.
//  - Locked, inject one 801-tick line -> err 1 clk; locked drops; relock after 3 vs edges.
//  - Hold hsync deasserted 2100 ticks while locked -> err at h_cnt=2047; locked=0.
//  - Frame of 524 lines in TRACK -> err; good resets; v_total=524.
//  - reset low mid-line while locked -> all outputs 0 within the same clk.
//    Release reset -> normal relock; random pix_en gaps give identical x/y/rx_valid.

Source files
------------

// File: rtl/vga_sync_decoder.sv
// Receive-side raster checker: measures line/frame periods from hsync/vsync,
// locks against the expected totals and recovers pixel coordinates once locked.
module vga_sync_decoder #(
  parameter int unsigned H_TOTAL         = 800,
  parameter int unsigned V_TOTAL         = 525,
  parameter int unsigned LOCK_FRAMES     = 2,
  parameter bit          SYNC_ACTIVE_LOW = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        pix_en,
  input  logic        hsync,
  input  logic        vsync,
  input  logic        valid,
  output logic [9:0]  x,
  output logic [8:0]  y,
  output logic        rx_valid,
  output logic        locked,
  output logic        err,
  output logic [10:0] h_total,
  output logic [9:0]  v_total
);

  localparam int unsigned HW = 11;
  localparam int unsigned VW = 10;
  localparam int unsigned XW = 10;
  localparam int unsigned YW = 9;
  localparam int unsigned GW = 8;
  localparam logic [HW-1:0] H_MAX = '1;
  localparam logic [VW-1:0] V_MAX = '1;
  localparam logic [XW-1:0] X_MAX = '1;
  localparam logic [YW-1:0] Y_MAX = '1;

  typedef enum logic [1:0] {SEARCH, TRACK, LOCKED} state_t;

  state_t        state_q, state_d;
  logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
  logic          h_seen_q, h_seen_d;
  logic [HW-1:0] h_cnt_q, h_cnt_d, h_total_q, h_total_d;
  logic [VW-1:0] v_cnt_q, v_cnt_d, v_total_q, v_total_d;
  logic [GW-1:0] good_q, good_d;
  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic          rx_valid_q, rx_valid_d, locked_q, locked_d, err_q, err_d;

  logic          hs_a, vs_a, hs_edge, vs_edge, fault;
  logic [VW-1:0] p_v;
  logic [GW-1:0] good_inc;

  // Sync polarity is normalised so hs_q/vs_q always hold "asserted".
  always_comb begin
    hs_a     = SYNC_ACTIVE_LOW ? ~hsync : hsync;
    vs_a     = SYNC_ACTIVE_LOW ? ~vsync : vsync;
    hs_edge  = pix_en & hs_a & ~hs_q;
    vs_edge  = pix_en & vs_a & ~vs_q;
    p_v      = (hs_edge && v_cnt_q != V_MAX) ? v_cnt_q + VW'(1) : v_cnt_q;
    good_inc = good_q + GW'(1);
    fault    = pix_en && (state_q != SEARCH) &&
               ((hs_edge && h_seen_q && h_cnt_q != HW'(H_TOTAL)) ||
                (vs_edge && p_v != VW'(V_TOTAL)) ||
                (h_cnt_q == H_MAX));
  end

  always_comb begin
    state_d    = state_q;
    hs_d       = hs_q;
    vs_d       = vs_q;
    de_d       = de_q;
    h_seen_d   = h_seen_q;
    h_cnt_d    = h_cnt_q;
    h_total_d  = h_total_q;
    v_cnt_d    = v_cnt_q;
    v_total_d  = v_total_q;
    good_d     = good_q;
    x_d        = x_q;
    y_d        = y_q;
    err_d      = 1'b0;
    rx_valid_d = pix_en & valid & (state_q == LOCKED);

    if (pix_en) begin
      hs_d = hs_a;
      vs_d = vs_a;
      de_d = valid;

      if (hs_edge) begin
        h_cnt_d   = HW'(1);
        h_total_d = h_cnt_q;
        h_seen_d  = 1'b1;
        if (v_cnt_q != V_MAX) v_cnt_d = v_cnt_q + VW'(1);
      end else if (h_cnt_q != H_MAX) begin
        h_cnt_d = h_cnt_q + HW'(1);
      end

      // A coincident hs edge belongs to the frame that is ending.
      if (vs_edge) begin
        v_cnt_d   = '0;
        v_total_d = p_v;
      end

      if (valid) begin
        x_d = !de_q ? '0 : (x_q == X_MAX) ? x_q : x_q + XW'(1);
      end
      if (vs_edge) begin
        y_d = '0;
      end else if (!valid && de_q && y_q != Y_MAX) begin
        y_d = y_q + YW'(1);
      end

      unique case (state_q)
        SEARCH: begin
          if (vs_edge) begin
            state_d = TRACK;
            good_d  = '0;
          end
        end
        TRACK: begin
          if (fault) begin
            state_d  = SEARCH;
            err_d    = 1'b1;
            h_seen_d = 1'b0;
          end else if (vs_edge) begin
            good_d = good_inc;
            if (good_inc >= GW'(LOCK_FRAMES)) state_d = LOCKED;
          end
        end
        LOCKED: begin
          if (fault) begin
            state_d  = SEARCH;
            err_d    = 1'b1;
            h_seen_d = 1'b0;
          end
        end
        default: state_d = SEARCH;
      endcase
    end

    locked_d = (state_d == LOCKED);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= SEARCH;
      hs_q       <= 1'b0;
      vs_q       <= 1'b0;
      de_q       <= 1'b0;
      h_seen_q   <= 1'b0;
      h_cnt_q    <= '0;
      h_total_q  <= '0;
      v_cnt_q    <= '0;
      v_total_q  <= '0;
      good_q     <= '0;
      x_q        <= '0;
      y_q        <= '0;
      rx_valid_q <= 1'b0;
      locked_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      hs_q       <= hs_d;
      vs_q       <= vs_d;
      de_q       <= de_d;
      h_seen_q   <= h_seen_d;
      h_cnt_q    <= h_cnt_d;
      h_total_q  <= h_total_d;
      v_cnt_q    <= v_cnt_d;
      v_total_q  <= v_total_d;
      good_q     <= good_d;
      x_q        <= x_d;
      y_q        <= y_d;
      rx_valid_q <= rx_valid_d;
      locked_q   <= locked_d;
      err_q      <= err_d;
    end
  end

  assign x        = x_q;
  assign y        = y_q;
  assign rx_valid = rx_valid_q;
  assign locked   = locked_q;
  assign err      = err_q;
  assign h_total  = h_total_q;
  assign v_total  = v_total_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a scaled-down 20x10 raster
// (12x5 active window at column 4, row 3), active-low syncs.
module tb_vga_sync_decoder;

  localparam int H  = 20;
  localparam int V  = 10;
  localparam int AW = 12;
  localparam int AH = 5;
  localparam int HX = 4;
  localparam int VY = 3;

  logic        clk = 1'b0;
  logic        reset, pix_en, hsync, vsync, valid;
  logic [9:0]  x;
  logic [8:0]  y;
  logic        rx_valid, locked, err;
  logic [10:0] h_total;
  logic [9:0]  v_total;

  vga_sync_decoder #(
    .H_TOTAL(H), .V_TOTAL(V), .LOCK_FRAMES(2), .SYNC_ACTIVE_LOW(1'b1)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .hsync(hsync), .vsync(vsync),
    .valid(valid), .x(x), .y(y), .rx_valid(rx_valid), .locked(locked),
    .err(err), .h_total(h_total), .v_total(v_total)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [9:0] cx;
    logic [8:0] cy;
  } coord_t;

  coord_t     exp_q[$];
  coord_t     mon_e;
  int         vectors    = 0;
  int         miscompares = 0;
  int         err_cnt    = 0;
  int         rx_cnt     = 0;
  int         pushed     = 0;
  int         gap_mode   = 1;
  logic       first_lock;
  logic [9:0] first_vt;

  task automatic check(input string name, input int act, input int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, req);
    end
  endtask

  // Monitor: every rx_valid strobe consumes one expected coordinate.
  always @(negedge clk) begin
    if (err === 1'b1) err_cnt++;
    if (rx_valid === 1'b1) begin
      rx_cnt++;
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL rx_unexpected: got x=%0d y=%0d, expected no pixel", x, y);
      end else begin
        mon_e = exp_q.pop_front();
        if (x !== mon_e.cx || y !== mon_e.cy) begin
          miscompares++;
          $display("FAIL rx_xy: got (%0d,%0d) expected (%0d,%0d)", x, y, mon_e.cx, mon_e.cy);
        end
      end
    end
  end

  // One pix_en tick, then a gap with garbage on the inputs.
  task automatic tick(input logic hs, input logic vs, input logic de);
    int g;
    hsync = hs; vsync = vs; valid = de; pix_en = 1'b1;
    @(posedge clk); #1;
    pix_en = 1'b0;
    g = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 3 : int'($urandom_range(0, 4));
    for (int i = 0; i < g; i++) begin
      hsync = 1'($urandom); vsync = 1'($urandom); valid = 1'($urandom);
      @(posedge clk); #1;
    end
  endtask

  task automatic send_frame(input int nlines, input bit lk, input int long_line,
                            input int stop_tick);
    int     n;
    int     len;
    logic   de;
    coord_t c;
    n = 0;
    for (int l = 0; l < nlines; l++) begin
      len = (l == long_line) ? H + 1 : H;
      for (int p = 0; p < len; p++) begin
        de = (l >= VY && l < VY + AH && p >= HX && p < HX + AW);
        if (de && lk && (long_line < 0 || l <= long_line)) begin
          c.cx = 10'(p - HX);
          c.cy = 9'(l - VY);
          exp_q.push_back(c);
          pushed++;
        end
        tick((p < 2) ? 1'b0 : 1'b1, (l < 2) ? 1'b0 : 1'b1, de);
        n++;
        if (n == 1) begin
          first_lock = locked;
          first_vt   = v_total;
        end
        if (n == stop_tick) return;
      end
    end
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_x"},        int'(x), 0);
    check({tag, "_y"},        int'(y), 0);
    check({tag, "_rx_valid"}, int'(rx_valid), 0);
    check({tag, "_locked"},   int'(locked), 0);
    check({tag, "_err"},      int'(err), 0);
    check({tag, "_h_total"},  int'(h_total), 0);
    check({tag, "_v_total"},  int'(v_total), 0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int err_at;
    reset = 1'b0; pix_en = 1'b0; hsync = 1'b1; vsync = 1'b1; valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b1;
    @(posedge clk); #1;

    // Nominal lock: vs edges 1..3 at the start of frames 0..2.
    gap_mode = 1;
    send_frame(V, 1'b0, -1, -1); check("lock_after_vs1", int'(first_lock), 0);
    send_frame(V, 1'b0, -1, -1); check("lock_after_vs2", int'(first_lock), 0);
    send_frame(V, 1'b1, -1, -1); check("lock_after_vs3", int'(first_lock), 1);
    send_frame(V, 1'b1, -1, -1);
    check("nominal_locked",  int'(locked), 1);
    check("nominal_h_total", int'(h_total), H);
    check("nominal_v_total", int'(v_total), V);
    check("nominal_err_cnt", err_cnt, 0);

    // One over-long line while locked.
    gap_mode = 2;
    send_frame(V, 1'b1, 5, -1);
    check("longline_err_cnt", err_cnt, 1);
    check("longline_locked",  int'(locked), 0);
    send_frame(V, 1'b0, -1, -1); check("relock1_vs1", int'(first_lock), 0);
    send_frame(V, 1'b0, -1, -1); check("relock1_vs2", int'(first_lock), 0);
    send_frame(V, 1'b1, -1, -1); check("relock1_vs3", int'(first_lock), 1);
    check("relock1_err_cnt", err_cnt, 1);

    // hsync held deasserted: h_cnt enters the hold at 20 and reaches 2047 on tick 2028.
    gap_mode = 0;
    err_at = -1;
    for (int k = 1; k <= 2100; k++) begin
      tick(1'b1, 1'b1, 1'b0);
      if (err === 1'b1 && err_at < 0) err_at = k;
    end
    check("hold_err_tick", err_at, 2028);
    check("hold_locked",   int'(locked), 0);
    check("hold_err_cnt",  err_cnt, 2);
    check("hold_h_total",  int'(h_total), H);

    // Short frame (9 lines) in TRACK.
    gap_mode = 1;
    send_frame(V, 1'b0, -1, -1);     check("short_vs1_lock", int'(first_lock), 0);
    send_frame(V - 1, 1'b0, -1, -1); check("short_vs2_lock", int'(first_lock), 0);
    send_frame(V, 1'b0, -1, -1);
    check("short_v_total", int'(first_vt), V - 1);
    check("short_lock",    int'(first_lock), 0);
    check("short_err_cnt", err_cnt, 3);
    send_frame(V, 1'b0, -1, -1); check("relock2_vs1", int'(first_lock), 0);
    send_frame(V, 1'b0, -1, -1); check("relock2_vs2", int'(first_lock), 0);
    send_frame(V, 1'b1, -1, -1); check("relock2_vs3", int'(first_lock), 1);

    // Reset mid-line while locked, after pixel (col 8, line 4).
    send_frame(V, 1'b1, -1, 89);
    check("midline_locked", int'(locked), 1);
    check("midline_x",      int'(x), 4);
    check("midline_y",      int'(y), 1);
    reset = 1'b0;
    #2;
    check_all_zero("async_reset");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Relock with random pix_en gaps.
    gap_mode = 2;
    send_frame(V, 1'b0, -1, -1); check("relock3_vs1", int'(first_lock), 0);
    send_frame(V, 1'b0, -1, -1); check("relock3_vs2", int'(first_lock), 0);
    send_frame(V, 1'b1, -1, -1); check("relock3_vs3", int'(first_lock), 1);
    send_frame(V, 1'b1, -1, -1);
    check("relock3_h_total", int'(h_total), H);
    check("relock3_v_total", int'(v_total), V);
    check("final_err_cnt",   err_cnt, 3);

    repeat (4) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size(), 0);
    check("rx_count",      rx_cnt, pushed);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
